// File: rtl/sseg_scan_ctrl.sv
// ============================================================================
//  Module   : sseg_scan_ctrl
//  Brief    : 4-digit seven-segment scan controller with enable, blink,
//             PWM brightness and a one-cycle dead time per digit slot.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_scan_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int BLINK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] in0,
    input  logic [6:0] in1,
    input  logic [6:0] in2,
    input  logic [6:0] in3,
    input  logic [3:0] dp_in,
    input  logic [3:0] digit_en,
    input  logic [3:0] blink_en,
    input  logic [2:0] brightness,
    output logic [3:0] an,
    output logic [6:0] sseg,
    output logic       dp,
    output logic [1:0] scan_idx
);

    localparam int c_pre_w = $clog2(TICK_DIV);
    localparam int c_blk_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int c_on_w  = c_pre_w + 1;

    localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(TICK_DIV - 1);
    localparam logic [c_blk_w-1:0] c_blk_max = c_blk_w'(BLINK_DIV - 1);
    localparam logic [c_on_w-1:0]  c_step    = c_on_w'(TICK_DIV / 8);

    logic [c_pre_w-1:0] r_pre_cnt;
    logic [c_blk_w-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [1:0]         r_scan_idx;
    logic [3:0]         r_en_s;
    logic [3:0]         r_bl_s;
    logic [2:0]         r_br_s;
    logic [3:0]         r_an;
    logic [6:0]         r_sseg;
    logic               r_dp;

    logic               w_tick;
    logic [c_on_w-1:0]  w_on;
    logic               w_lit;
    logic [6:0]         w_seg_sel;
    logic [3:0]         w_an_sel;

    assign w_tick = (r_pre_cnt == c_pre_max);

    always_comb begin
        w_on     = ({{(c_on_w-3){1'b0}}, r_br_s} + c_on_w'(1)) * c_step;
        w_an_sel = ~(4'b0001 << r_scan_idx);
        // pre_cnt==0 is the dead time that keeps the previous digit from ghosting
        w_lit    = r_en_s[r_scan_idx]
                 & ~(r_bl_s[r_scan_idx] & r_blink_phase)
                 & (r_pre_cnt != '0)
                 & ({1'b0, r_pre_cnt} < w_on);
        w_seg_sel = 7'h7F;
        case (r_scan_idx)
            2'd0:    w_seg_sel = in0;
            2'd1:    w_seg_sel = in1;
            2'd2:    w_seg_sel = in2;
            default: w_seg_sel = in3;
        endcase
    end

    // Slot sequencing; the shadows only move on a tick so mid-slot changes wait
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre_cnt     <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_scan_idx    <= 2'd0;
            r_en_s        <= digit_en;
            r_bl_s        <= blink_en;
            r_br_s        <= brightness;
        end else if (w_tick) begin
            r_pre_cnt  <= '0;
            r_scan_idx <= r_scan_idx + 2'd1;
            r_en_s     <= digit_en;
            r_bl_s     <= blink_en;
            r_br_s     <= brightness;
            if (r_blink_cnt == c_blk_max) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_blk_w'(1);
            end
        end else begin
            r_pre_cnt <= r_pre_cnt + c_pre_w'(1);
        end
    end

    // Pin drivers registered together so an and sseg always change on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an   <= 4'b1111;
            r_sseg <= 7'h7F;
            r_dp   <= 1'b1;
        end else if (w_lit) begin
            r_an   <= w_an_sel;
            r_sseg <= w_seg_sel;
            r_dp   <= ~dp_in[r_scan_idx];
        end else begin
            r_an   <= 4'b1111;
            r_sseg <= 7'h7F;
            r_dp   <= 1'b1;
        end
    end

    assign an       = r_an;
    assign sseg     = r_sseg;
    assign dp       = r_dp;
    assign scan_idx = r_scan_idx;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
// ============================================================================
//  Module   : tb_sseg_scan_ctrl
//  Brief    : Self-checking bench for sseg_scan_ctrl against a cycle-count
//             arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sseg_scan_ctrl;

    localparam int TICK_DIV  = 16;
    localparam int BLINK_DIV = 4;
    localparam int SLOT      = TICK_DIV;
    localparam int FRAME     = 4 * TICK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] in0, in1, in2, in3;
    logic [3:0] dp_in, digit_en, blink_en;
    logic [2:0] brightness;
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;
    logic [1:0] scan_idx;

    int checks   = 0;
    int failures = 0;
    int lit_cnt  = 0;
    int an13_low = 0;
    bit rnd_seg  = 1'b0;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blink_en   (blink_en),
        .brightness (brightness),
        .an         (an),
        .sseg       (sseg),
        .dp         (dp),
        .scan_idx   (scan_idx)
    );

    // Reference: everything derives from the number of cycles since reset release
    int         m_cyc = 0;
    logic [3:0] m_en, m_bl;
    logic [2:0] m_br;
    logic [3:0] exp_an   = 4'hF;
    logic [6:0] exp_sseg = 7'h7F;
    logic       exp_dp   = 1'b1;
    logic [1:0] exp_scan = 2'd0;

    function automatic logic [11:0] model_out(input int cyc, input logic [3:0] en,
                                              input logic [3:0] bl, input logic [2:0] br,
                                              input logic [6:0] p0, input logic [6:0] p1,
                                              input logic [6:0] p2, input logic [6:0] p3,
                                              input logic [3:0] dpr);
        int pre, slot, idx, phase, on_cycles;
        bit lit;
        logic [6:0] pat[4];
        logic [3:0] a;
        pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
        pre       = cyc % SLOT;
        slot      = cyc / SLOT;
        idx       = slot % 4;
        phase     = (slot / BLINK_DIV) % 2;
        on_cycles = (int'(br) + 1) * (TICK_DIV / 8);
        lit = en[idx] && !(bl[idx] && phase == 1) && pre >= 1 && pre < on_cycles;
        a = 4'hF;
        a[idx] = 1'b0;
        if (lit) return {a, pat[idx], ~dpr[idx]};
        return {4'hF, 7'h7F, 1'b1};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cyc    <= 0;
            m_en     <= digit_en;
            m_bl     <= blink_en;
            m_br     <= brightness;
            exp_an   <= 4'hF;
            exp_sseg <= 7'h7F;
            exp_dp   <= 1'b1;
            exp_scan <= 2'd0;
        end else begin
            {exp_an, exp_sseg, exp_dp} <= model_out(m_cyc, m_en, m_bl, m_br,
                                                    in0, in1, in2, in3, dp_in);
            if (m_cyc % SLOT == SLOT - 1) begin
                m_en <= digit_en;
                m_bl <= blink_en;
                m_br <= brightness;
            end
            m_cyc    <= m_cyc + 1;
            exp_scan <= 2'(((m_cyc + 1) / SLOT) % 4);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("an", {28'd0, an}, {28'd0, exp_an});
            chk("sseg", {25'd0, sseg}, {25'd0, exp_sseg});
            chk("dp", {31'd0, dp}, {31'd0, exp_dp});
            chk("scan_idx", {30'd0, scan_idx}, {30'd0, exp_scan});
            chk("an_at_most_one_low", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
            if (an != 4'hF) lit_cnt++;
            if (!an[1] || !an[3]) an13_low++;
            if (rnd_seg) begin
                in0 = 7'($urandom); in1 = 7'($urandom);
                in2 = 7'($urandom); in3 = 7'($urandom);
            end
        end
    endtask

    task automatic align_to(input int pos);
        int k = 0;
        while ((m_cyc % FRAME) != pos && k < 4 * FRAME) begin
            run_cycles(1);
            k++;
        end
        chk("align_bound", 32'(m_cyc % FRAME), 32'(pos));
    endtask

    initial begin
        // Reset with full brightness and fixed digit patterns
        digit_en = 4'hF; blink_en = 4'h0; brightness = 3'd7; dp_in = 4'h0;
        in0 = 7'h40; in1 = 7'h79; in2 = 7'h24; in3 = 7'h30;
        reset = 1'b1;
        run_cycles(5);
        reset = 1'b0;
        lit_cnt = 0;
        run_cycles(FRAME);
        chk("full_duty_lit_cycles", 32'(lit_cnt), 32'd60);

        // Dimmest level: one lit cycle per slot
        brightness = 3'd0;
        run_cycles(SLOT);
        lit_cnt = 0;
        run_cycles(FRAME);
        chk("min_duty_lit_cycles", 32'(lit_cnt), 32'd4);

        // Digits 1 and 3 disabled
        brightness = 3'd7;
        digit_en   = 4'b0101;
        run_cycles(SLOT);
        lit_cnt = 0; an13_low = 0;
        run_cycles(FRAME);
        chk("disabled_lit_cycles", 32'(lit_cnt), 32'd30);
        chk("disabled_digits_low", 32'(an13_low), 32'd0);

        // Blink on digit 0 across several frames
        digit_en = 4'hF;
        blink_en = 4'b0001;
        run_cycles(4 * FRAME);

        // Brightness drop in the middle of slot 2
        blink_en = 4'h0;
        align_to(2 * SLOT + 5);
        brightness = 3'd0;
        run_cycles(3 * SLOT);

        // Randomized enables, blink, brightness, decimal points and patterns
        rnd_seg = 1'b1;
        for (int r = 0; r < 24; r++) begin
            digit_en   = 4'($urandom);
            blink_en   = 4'($urandom);
            brightness = 3'($urandom);
            dp_in      = 4'($urandom);
            run_cycles($urandom_range(1, 40));
        end

        // Mid-scan reset at slot 2, pre_cnt 9
        digit_en = 4'hF; blink_en = 4'h0; brightness = 3'd7; dp_in = 4'b1000;
        align_to(2 * SLOT + 9);
        reset = 1'b1;
        run_cycles(1);
        chk("reset_scan_idx", {30'd0, scan_idx}, 32'd0);
        chk("reset_an", {28'd0, an}, 32'hF);
        reset = 1'b0;
        run_cycles(2);
        chk("first_lit_after_reset", {28'd0, an}, 32'hE);
        run_cycles(2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Scan controller for the 4-digit seven-segment display. It replaces a free-running divider plus mux state machine with a single sequenced block. The block time-multiplexes four pre-decoded segment patterns onto the shared an/sseg/dp pins, and adds per-digit enable, per-digit blink, 8-level PWM brightness and a one-cycle anti-ghosting dead time. It sits between the hex-to-segment decoders and the board pins, and is clocked directly from the board clk.

Parameters:
TICK_DIV, 100000, clk cycles per digit slot; must be a multiple of 8 and >= 16.
BLINK_DIV, 250, slots per blink half-period; must be >= 1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in0  in  7  digit 0 segment pattern, active-low (a..g)
in1  in  7  digit 1 pattern
in2  in  7  digit 2 pattern
in3  in  7  digit 3 pattern
dp_in  in  4  decimal point request per digit, active-high
digit_en  in  4  per-digit enable, 1 = shown
blink_en  in  4  per-digit blink enable
brightness  in  3  duty level, 0 = dimmest, 7 = full
an  out  4  anodes, active-low, one-hot-low when lit
sseg  out  7  segment cathodes, active-low
dp  out  1  decimal point cathode, active-low
scan_idx  out  2  digit slot currently being scanned

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - an=4'b1111, sseg=7'h7F, dp=1, scan_idx=0.
  - pre_cnt=0, blink_cnt=0, blink_phase=0.
  - Shadow registers en_s, bl_s and br_s load digit_en, blink_en and brightness while reset is high.
- pre_cnt: counts 0..TICK_DIV-1, then wraps to 0. tick = (pre_cnt==TICK_DIV-1).
- On tick:
  - scan_idx increments, 3 -> 0 wrap.
  - en_s, bl_s and br_s reload from their inputs. This is the only point where they change outside reset, so mid-slot input changes never glitch the current slot.
  - blink_cnt increments. When it reaches BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
- Slot order after reset: digit 0 (an[0]), 1, 2, 3, 0, ...
- Lit condition for slot i, evaluated from registered state each cycle:
  - en_s[i]=1, and
  - NOT (bl_s[i] AND blink_phase), and
  - 1 <= pre_cnt < ON, where ON = (br_s+1)*(TICK_DIV/8).
- pre_cnt==0 is always dark. This is the dead time.
- br_s=7 gives TICK_DIV-1 lit cycles per slot. br_s=0 gives TICK_DIV/8-1 lit cycles.
- Outputs are registered, with 1-cycle latency from counter state:
  - Lit: an = ~(4'b0001<<scan_idx), sseg = in[scan_idx], dp = ~dp_in[scan_idx].
  - Dark: an=4'b1111, sseg=7'h7F, dp=1.
  - Segment inputs are sampled every cycle, not shadowed.
- scan_idx output is the counter value itself (no extra latency). an therefore lags scan_idx by one cycle at slot boundaries.
- At most one an bit is low in any cycle. an is never low while sseg carries the previous digit's pattern.
- Reset mid-scan: outputs return to reset values on the next edge; the scan restarts at digit 0 after release.
- Simultaneous tick and blink wrap on the same edge: scan_idx, shadows and blink_phase all update on that edge. The new slot uses the new blink_phase.

Test Plan:
(all with TICK_DIV=16, BLINK_DIV=4)
1. Reset held for 5 cycles, then released. digit_en=F, blink_en=0, brightness=7, in0..in3=7'h40,7'h79,7'h24,7'h30.
   -> During reset: an=1111, sseg=7F, dp=1.
   -> After release, an cycles 1110, 1101, 1011, 0111. Each is low for 15 cycles, then high for 1. sseg matches the selected digit whenever an is low.
2. brightness=0 -> each digit low for exactly 1 cycle per 16-cycle slot (pre_cnt=1). an=1111 the remaining 15 cycles.
3. digit_en=4'b0101 -> an[1] and an[3] never low. During slots 1 and 3: sseg=7F, dp=1.
4. blink_en=4'b0001 -> digit 0 lit in frame 0, dark in frame 1, lit in frame 2 (64-cycle frames). Digits 1-3 lit every frame.
5. brightness changed 7 -> 0 at pre_cnt=5 of slot 2 -> slot 2 stays at full duty. Slot 3 is lit only at pre_cnt=1.
6. reset asserted at scan_idx=2, pre_cnt=9 for 1 cycle -> next cycle an=1111, scan_idx=0. After release the first lit digit is digit 0, at pre_cnt=1.
   dp_in=4'b1000 -> dp=0 only while an=0111.
